// File: rtl/ap_ctrl_pkg.sv
// ap_ctrl_pkg: FSM state type and default widths shared by the ap_ctrl_chain driver and its bench.
package ap_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_e;
    localparam int TXN_W_DEF = 16;
    localparam int CYC_W_DEF = 32;
    localparam int DEPTH_DEF = 4;
    localparam int DELAY_W   = 8;
endpackage

// File: rtl/ts_fifo.sv
// ts_fifo: synchronous DEPTH x W timestamp FIFO; push and pop may coincide even when full.
// Ports: clock/reset (sync, active-high), clr flushes, push/din write, pop retires head,
// dout shows the head entry, empty/full report occupancy.
module ts_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;
    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction
    always_comb begin
        empty   = cnt_q == '0;
        full    = cnt_q == (AW+1)'(DEPTH);
        do_pop  = pop && !empty;
        // A pop in the same cycle frees the slot the push needs.
        do_push = push && (!full || do_pop);
        wr_d    = do_push ? inc(wr_q) : wr_q;
        rd_d    = do_pop ? inc(rd_q) : rd_q;
        cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        dout    = mem_q[rd_q];
    end
    always_ff @(posedge clock) begin
        if (reset || clr) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_q] <= din;
    end
endmodule

// File: rtl/ap_ctrl_chain_driver.sv
// ap_ctrl_chain_driver: issues a commanded number of ap_ctrl_chain transactions to an HLS core,
// throttles ap_continue by a programmable delay and reports per-run latency statistics.
// Ports: clock/reset (sync, active-high); cmd_valid/cmd_ready/cmd_num_txn/cmd_cont_delay command
// a run; ap_start/ap_ready/ap_done/ap_continue/ap_idle connect to the core; busy/finish give run
// status; started_cnt/done_cnt/last_latency/max_latency/total_cycles report the run;
// err_protocol is a sticky handshake-violation flag cleared by the next command.
module ap_ctrl_chain_driver
    import ap_ctrl_pkg::*;
#(
    parameter int TXN_W = TXN_W_DEF,
    parameter int CYC_W = CYC_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [TXN_W-1:0]   cmd_num_txn,
    input  logic [DELAY_W-1:0] cmd_cont_delay,
    output logic               ap_start,
    input  logic               ap_ready,
    input  logic               ap_done,
    output logic               ap_continue,
    input  logic               ap_idle,
    output logic               busy,
    output logic               finish,
    output logic [TXN_W-1:0]   started_cnt,
    output logic [TXN_W-1:0]   done_cnt,
    output logic [CYC_W-1:0]   last_latency,
    output logic [CYC_W-1:0]   max_latency,
    output logic [CYC_W-1:0]   total_cycles,
    output logic               err_protocol
);
    state_e             state_q, state_d;
    logic [TXN_W-1:0]   num_txn_q, num_txn_d, started_q, started_d, done_q, done_d, out_q, out_d;
    logic [DELAY_W-1:0] cont_q, cont_d, wait_q, wait_d, wait_eff;
    logic [CYC_W-1:0]   cyc_q, cyc_d, last_q, last_d, max_q, max_d, total_q, total_d, lat, ts_head;
    logic               ap_start_q, ap_start_d, pend_q, pend_d, err_q, err_d;
    logic               cmd_acc, start_acc, done_acc, fifo_empty, fifo_full, unused_ok;
    ts_fifo #(.DEPTH(DEPTH), .W(CYC_W)) u_fifo (
        .clock (clock),
        .reset (reset),
        .clr   (cmd_acc),
        .push  (start_acc),
        .pop   (done_acc),
        .din   (cyc_q),
        .dout  (ts_head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );
    always_comb begin
        cmd_acc     = cmd_valid && state_q == IDLE;
        start_acc   = ap_start_q && ap_ready;
        out_q       = started_q - done_q;
        // The first cycle of a done sees the freshly programmed delay, later cycles the countdown.
        wait_eff    = (ap_done && !pend_q) ? cont_q : wait_q;
        ap_continue = state_q == RUN && ap_done && wait_eff == '0;
        // A done with nothing outstanding is spurious: flagged, never counted.
        done_acc    = ap_continue && out_q != '0;
        lat         = cyc_q - ts_head;
        num_txn_d   = cmd_acc ? cmd_num_txn : num_txn_q;
        cont_d      = cmd_acc ? cmd_cont_delay : cont_q;
        cyc_d       = cmd_acc ? '0 : (state_q == RUN && cyc_q != '1) ? cyc_q + 1'b1 : cyc_q;
        started_d   = cmd_acc ? '0 : started_q + TXN_W'(start_acc);
        done_d      = cmd_acc ? '0 : done_q + TXN_W'(done_acc);
        out_d       = started_d - done_d;
        last_d      = cmd_acc ? '0 : done_acc ? lat : last_q;
        max_d       = cmd_acc ? '0 : (done_acc && lat > max_q) ? lat : max_q;
        total_d     = cmd_acc ? '0 : done_acc ? cyc_q : total_q;
        pend_d      = !cmd_acc && ap_done && !ap_continue;
        wait_d      = (cmd_acc || wait_eff == '0) ? '0 : wait_eff - 1'b1;
        err_d       = !cmd_acc && (err_q || (ap_done && out_q == '0) ||
                      (ap_ready && !ap_start_q) || (pend_q && !ap_done));
        state_d     = state_q == IDLE ? (cmd_acc ? (cmd_num_txn == '0 ? FINISH : RUN) : IDLE)
                    : state_q == RUN ? (done_d == num_txn_q ? FINISH : RUN)
                    : IDLE;
        // Start only drops through an accept or a run end, so it never retracts unacknowledged.
        ap_start_d  = state_d == RUN && started_d < num_txn_d && out_d < TXN_W'(DEPTH);
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            num_txn_q  <= '0;
            cont_q     <= '0;
            cyc_q      <= '0;
            started_q  <= '0;
            done_q     <= '0;
            last_q     <= '0;
            max_q      <= '0;
            total_q    <= '0;
            wait_q     <= '0;
            pend_q     <= 1'b0;
            err_q      <= 1'b0;
            ap_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            num_txn_q  <= num_txn_d;
            cont_q     <= cont_d;
            cyc_q      <= cyc_d;
            started_q  <= started_d;
            done_q     <= done_d;
            last_q     <= last_d;
            max_q      <= max_d;
            total_q    <= total_d;
            wait_q     <= wait_d;
            pend_q     <= pend_d;
            err_q      <= err_d;
            ap_start_q <= ap_start_d;
        end
    end
    assign cmd_ready    = state_q == IDLE;
    assign busy         = state_q != IDLE;
    assign finish       = state_q == FINISH;
    assign ap_start     = ap_start_q;
    assign started_cnt  = started_q;
    assign done_cnt     = done_q;
    assign last_latency = last_q;
    assign max_latency  = max_q;
    assign total_cycles = total_q;
    assign err_protocol = err_q;
    assign unused_ok    = ^{ap_idle, fifo_empty, fifo_full};
endmodule

// File: tb/tb_ap_ctrl_chain_driver.sv
// tb_ap_ctrl_chain_driver: scenario bench with a behavioural HLS core and a timestamp scoreboard.
module tb_ap_ctrl_chain_driver;
    localparam int TXN_W = 16;
    localparam int CYC_W = 32;
    localparam int DEPTH = 4;
    logic clock = 1'b0, reset = 1'b1, cmd_valid = 1'b0;
    logic [TXN_W-1:0] cmd_num_txn = '0;
    logic [7:0] cmd_cont_delay = '0;
    logic ap_ready = 1'b0, ap_done = 1'b0, ap_idle = 1'b1;
    logic cmd_ready, ap_start, ap_continue, busy, finish, err_protocol;
    logic [TXN_W-1:0] started_cnt, done_cnt;
    logic [CYC_W-1:0] last_latency, max_latency, total_cycles;
    int checks = 0, failures = 0;
    int edge_n = 0, done_n = 0, num_exp = 0, core_lat = 1, dn_t = -1, max_exp = 0, full_seen = 0, cur_delay = 0;
    bit in_run = 0, ready_rand = 0, done_force = 0, prev_hold = 0;
    int sb_q[$];
    always #5 clock = ~clock;
    ap_ctrl_chain_driver #(.TXN_W(TXN_W), .CYC_W(CYC_W), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_num_txn(cmd_num_txn), .cmd_cont_delay(cmd_cont_delay), .ap_start(ap_start),
        .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue), .ap_idle(ap_idle),
        .busy(busy), .finish(finish), .started_cnt(started_cnt), .done_cnt(done_cnt),
        .last_latency(last_latency), .max_latency(max_latency), .total_cycles(total_cycles),
        .err_protocol(err_protocol)
    );
    task automatic step();
        logic exp_cont;
        int lat;
        bit s_acc, d_acc;
        ap_ready = ap_start && (!ready_rand || $urandom_range(1) == 1);
        ap_done = done_force || (sb_q.size() > 0 && edge_n + 1 - sb_q[0] >= core_lat);
        if (ap_done && dn_t < 0) dn_t = edge_n;
        #1;
        if (prev_hold) begin
            checks++;
            if (ap_start !== 1'b1) begin failures++; $display("FAIL start_hold: ap_start=%b want 1", ap_start); end
        end
        if (in_run && sb_q.size() >= DEPTH) begin
            full_seen++;
            checks++;
            if (ap_start !== 1'b0) begin failures++; $display("FAIL start_depth: ap_start=%b want 0 outstanding=%0d", ap_start, sb_q.size()); end
        end
        if (ap_done) begin
            exp_cont = in_run && (edge_n - dn_t >= cur_delay);
            checks++;
            if (ap_continue !== exp_cont) begin failures++; $display("FAIL continue_timing: ap_continue=%b want %b at edge %0d", ap_continue, exp_cont, edge_n); end
        end
        s_acc = ap_start && ap_ready;
        d_acc = ap_done && ap_continue && sb_q.size() > 0;
        prev_hold = ap_start && !ap_ready;
        lat = 0;
        @(posedge clock);
        edge_n++;
        if (d_acc) begin
            lat = edge_n - sb_q.pop_front();
            done_n++;
            if (lat > max_exp) max_exp = lat;
        end
        if (s_acc) sb_q.push_back(edge_n);
        if (d_acc || !ap_done) dn_t = -1;
        if (done_n == num_exp) in_run = 0;
        @(negedge clock);
        if (d_acc) begin
            checks++;
            if (last_latency !== CYC_W'(lat)) begin failures++; $display("FAIL last_latency: got %0d want %0d", last_latency, lat); end
            checks++;
            if (done_cnt !== TXN_W'(done_n)) begin failures++; $display("FAIL done_cnt: got %0d want %0d", done_cnt, done_n); end
        end
    endtask
    task automatic issue(input int n, input int d);
        checks++;
        if (cmd_ready !== 1'b1) begin failures++; $display("FAIL cmd_ready_idle: got %b want 1", cmd_ready); end
        cmd_valid = 1'b1;
        cmd_num_txn = TXN_W'(n);
        cmd_cont_delay = 8'(d);
        @(posedge clock);
        edge_n = 0;
        done_n = 0;
        num_exp = n;
        cur_delay = d;
        in_run = n != 0;
        dn_t = -1;
        max_exp = 0;
        prev_hold = 0;
        sb_q.delete();
        @(negedge clock);
        cmd_valid = 1'b0;
    endtask
    task automatic run_until(input int limit);
        for (int i = 0; i < limit && done_n < num_exp; i++) step();
        checks++;
        if (done_n != num_exp) begin failures++; $display("FAIL timeout: done %0d want %0d", done_n, num_exp); end
    endtask
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++;
        if ({cmd_ready, ap_start, ap_continue, busy, finish, err_protocol} !== 6'b100000) begin
            failures++; $display("FAIL reset_flags: got %b want 100000", {cmd_ready, ap_start, ap_continue, busy, finish, err_protocol});
        end
        checks++;
        if ({started_cnt, done_cnt, last_latency, max_latency, total_cycles} !== '0) begin
            failures++; $display("FAIL reset_counters: started=%0d done=%0d last=%0d max=%0d total=%0d want all 0", started_cnt, done_cnt, last_latency, max_latency, total_cycles);
        end
        reset = 1'b0;
    endtask
    task automatic test_single();
        core_lat = 5;
        issue(1, 0);
        run_until(40);
        checks++;
        if (last_latency !== 32'd5) begin failures++; $display("FAIL single_last: got %0d want 5", last_latency); end
        checks++;
        if (max_latency !== 32'd5) begin failures++; $display("FAIL single_max: got %0d want 5", max_latency); end
        checks++;
        if (total_cycles !== 32'd5) begin failures++; $display("FAIL single_total: got %0d want 5", total_cycles); end
        checks++;
        if ({finish, busy} !== 2'b11) begin failures++; $display("FAIL single_finish: finish,busy=%b want 11", {finish, busy}); end
        step();
        checks++;
        if ({finish, busy, cmd_ready} !== 3'b001) begin failures++; $display("FAIL single_idle: finish,busy,cmd_ready=%b want 001", {finish, busy, cmd_ready}); end
    endtask
    task automatic test_depth();
        core_lat = 10;
        full_seen = 0;
        issue(8, 0);
        run_until(200);
        checks++;
        if ({started_cnt, done_cnt} !== {16'd8, 16'd8}) begin failures++; $display("FAIL depth_counts: started=%0d done=%0d want 8 8", started_cnt, done_cnt); end
        checks++;
        if (max_latency !== 32'd10) begin failures++; $display("FAIL depth_max: got %0d want 10", max_latency); end
        checks++;
        if (err_protocol !== 1'b0) begin failures++; $display("FAIL depth_err: got %b want 0", err_protocol); end
        checks++;
        if (total_cycles !== CYC_W'(edge_n - 1)) begin failures++; $display("FAIL depth_total: got %0d want %0d", total_cycles, edge_n - 1); end
        checks++;
        if (full_seen == 0) begin failures++; $display("FAIL depth_full: outstanding never reached %0d", DEPTH); end
        repeat (2) step();
    endtask
    task automatic test_delay();
        core_lat = 4;
        issue(2, 3);
        run_until(100);
        checks++;
        if ({last_latency, max_latency} !== {32'd10, 32'd10}) begin failures++; $display("FAIL delay_lat: last=%0d max=%0d want 10 10", last_latency, max_latency); end
        checks++;
        if ({done_cnt, err_protocol} !== {16'd2, 1'b0}) begin failures++; $display("FAIL delay_done: done=%0d err=%b want 2 0", done_cnt, err_protocol); end
        repeat (2) step();
    endtask
    task automatic test_stall();
        core_lat = 3;
        ready_rand = 1;
        issue(3, 1);
        run_until(300);
        ready_rand = 0;
        checks++;
        if (max_latency !== CYC_W'(max_exp)) begin failures++; $display("FAIL stall_max: got %0d want %0d", max_latency, max_exp); end
        checks++;
        if ({started_cnt, err_protocol} !== {16'd3, 1'b0}) begin failures++; $display("FAIL stall_counts: started=%0d err=%b want 3 0", started_cnt, err_protocol); end
        repeat (2) step();
    endtask
    task automatic test_zero();
        issue(0, 0);
        checks++;
        if ({finish, ap_start} !== 2'b10) begin failures++; $display("FAIL zero_finish: finish,ap_start=%b want 10", {finish, ap_start}); end
        checks++;
        if ({started_cnt, done_cnt} !== '0) begin failures++; $display("FAIL zero_counts: started=%0d done=%0d want 0 0", started_cnt, done_cnt); end
        step();
        checks++;
        if ({finish, busy, ap_start} !== 3'b000) begin failures++; $display("FAIL zero_idle: finish,busy,ap_start=%b want 000", {finish, busy, ap_start}); end
    endtask
    task automatic test_spurious();
        done_force = 1;
        step();
        done_force = 0;
        checks++;
        if ({err_protocol, done_cnt} !== {1'b1, 16'd0}) begin failures++; $display("FAIL spurious_err: err=%b done=%0d want 1 0", err_protocol, done_cnt); end
        repeat (3) step();
        checks++;
        if (err_protocol !== 1'b1) begin failures++; $display("FAIL spurious_sticky: got %b want 1", err_protocol); end
        core_lat = 2;
        issue(1, 0);
        checks++;
        if (err_protocol !== 1'b0) begin failures++; $display("FAIL spurious_clear: got %b want 0", err_protocol); end
        run_until(30);
        checks++;
        if ({last_latency, err_protocol} !== {32'd2, 1'b0}) begin failures++; $display("FAIL spurious_run: last=%0d err=%b want 2 0", last_latency, err_protocol); end
        repeat (2) step();
    endtask
    task automatic test_reset_midrun();
        core_lat = 50;
        issue(4, 0);
        repeat (2) step();
        checks++;
        if (sb_q.size() != 2 || started_cnt !== 16'd2) begin failures++; $display("FAIL midrun_setup: started=%0d want 2", started_cnt); end
        reset = 1'b1;
        ap_ready = 1'b0;
        ap_done = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if ({ap_start, ap_continue, cmd_ready, busy, err_protocol} !== 5'b00100) begin
            failures++; $display("FAIL midrun_flags: start,cont,cmd_ready,busy,err=%b want 00100", {ap_start, ap_continue, cmd_ready, busy, err_protocol});
        end
        checks++;
        if ({started_cnt, done_cnt, last_latency, max_latency, total_cycles} !== '0) begin
            failures++; $display("FAIL midrun_counters: started=%0d done=%0d last=%0d want all 0", started_cnt, done_cnt, last_latency);
        end
        @(negedge clock);
        reset = 1'b0;
        ap_done = 1'b0;
        sb_q.delete();
        in_run = 0;
        num_exp = 0;
        done_n = 0;
        prev_hold = 0;
        dn_t = -1;
        step();
        core_lat = 3;
        issue(1, 0);
        run_until(30);
        checks++;
        if ({last_latency, done_cnt} !== {32'd3, 16'd1}) begin failures++; $display("FAIL midrun_recover: last=%0d done=%0d want 3 1", last_latency, done_cnt); end
        repeat (2) step();
    endtask
    initial begin
        test_reset();
        test_single();
        test_depth();
        test_delay();
        test_stall();
        test_zero();
        test_spurious();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ap_ctrl_chain_driver.md
Name: ap_ctrl_chain_driver

Overview:
- Synthesizable initiator for the HLS block-level ap_ctrl_chain handshake (ap_start/ap_ready/ap_done/ap_continue/ap_idle).
- Issues a commanded number of transactions to an HLS core and applies programmable ap_continue back-pressure.
- Timestamps each transaction and reports latency and cycle statistics.
- Sits between a host/test controller and the HLS core's control port. It is the active counterpart to the passive module-status monitors.

Parameters:
TXN_W, 16, width of transaction count fields
CYC_W, 32, width of cycle/timestamp/latency counters
DEPTH, 4, max outstanding transactions (started, not yet done-accepted); power of two, >=1

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  high in IDLE only
cmd_num_txn  in  TXN_W  transactions to issue
cmd_cont_delay  in  8  cycles from first ap_done observation to ap_continue
ap_start  out  1  to core
ap_ready  in  1  from core
ap_done  in  1  from core
ap_continue  out  1  to core
ap_idle  in  1  from core (status only)
busy  out  1  state != IDLE
finish  out  1  one-cycle pulse at run completion
started_cnt  out  TXN_W  starts accepted this run
done_cnt  out  TXN_W  dones accepted this run
last_latency  out  CYC_W  latency of most recent done-accepted txn
max_latency  out  CYC_W  max latency this run
total_cycles  out  CYC_W  cycles from cmd accept to last done accept
err_protocol  out  1  sticky protocol error

Behaviour:
- Reset: all outputs 0 except cmd_ready=1. State=IDLE. FIFO empty. Reset mid-run aborts immediately; ap_start and ap_continue are 0 from the next edge.
- FSM states: IDLE, RUN, FINISH.
  - IDLE -> RUN on cmd_valid&&cmd_ready. num_txn and cont_delay are latched; counters, stats and err are cleared; cyc counter is cleared to 0.
  - If num_txn==0: IDLE -> FINISH directly.
  - RUN -> FINISH on the edge where done_cnt reaches num_txn.
  - FINISH -> IDLE after one cycle. finish=1 only in FINISH.
- cyc counter: increments every cycle in RUN; saturates at all-ones.
- Start side:
  - ap_start is registered.
  - Start is accepted at an edge with ap_start&&ap_ready. That edge pushes the current cyc value into the timestamp FIFO and increments started_cnt.
  - Next ap_start = RUN && (started_cnt_next < num_txn) && (outstanding_next < DEPTH), where outstanding = started_cnt - done_cnt.
  - ap_start never drops without ap_ready, except on reset.
- Done side:
  - wait_cnt is loaded with cont_delay when ap_done is high and done_pending==0; done_pending is then set.
  - wait_cnt decrements while >0.
  - ap_continue = RUN && ap_done && done_pending_or_first && wait_cnt_eff==0. This is combinational, so cont_delay=0 gives ap_continue in the same cycle as ap_done.
  - Done is accepted on ap_done&&ap_continue. On accept: pop FIFO, last_latency = cyc - ts_head, max_latency = max(max_latency, last_latency), done_cnt++, total_cycles = cyc, done_pending cleared.
- Simultaneous start-accept and done-accept in one cycle: FIFO pushes and pops together; outstanding is unchanged.
- err_protocol is set (sticky until next cmd accept) on any of:
  - ap_done while outstanding==0;
  - ap_ready while ap_start==0;
  - ap_done deasserted before ap_continue while done_pending.
- On error the FSM continues; a spurious done is not counted.
- Width rules: latency arithmetic is modulo CYC_W. Counters never wrap within a run because num_txn < 2^TXN_W.

Decomposition:
- Package ap_ctrl_pkg: state enum (IDLE, RUN, FINISH), default widths, cont_delay width constant.
- Sub-module ts_fifo: synchronous FIFO, DEPTH x CYC_W, with push/pop/empty/full. Simultaneous push and pop are legal even when full.

Test Plan:
- num_txn=1, delay=0; core model asserts ready with start and done 5 cycles later -> last_latency=5, max_latency=5, done_cnt=1, finish pulses one cycle after done accept, busy low after.
- num_txn=8, DEPTH=4; core always ready, done latency 10 -> ap_start low while outstanding=4, started_cnt=done_cnt=8, max_latency=10, err=0.
- num_txn=2, delay=3; done asserted at cycle T -> ap_continue first high at T+3, latency includes the 3-cycle stall, no second done accepted early.
- num_txn=0 -> finish pulses on the cycle after cmd accept, ap_start never asserted, counters 0.
- Spurious ap_done before any start -> err_protocol=1 and stays 1, done_cnt unchanged; cleared on next cmd accept.
- Reset asserted mid-run with 2 outstanding -> next cycle ap_start=0, ap_continue=0, all counters 0, cmd_ready=1.
